pwm_audio_out: RTL and testbench
================================

// Module: pwm_audio_out
// PURPOSE
//  Output stage directly downstream of the tone generator's mixer. Latches each mixed sample (signed 16-bit,
//  one valid pulse per sample), converts it to offset binary and drives a 1-bit PWM pin for an external RC filter.
//  The truncated LSBs of each sample go into a first-order error-feedback (noise-shaping) accumulator. One sample
//  spans several PWM periods; a pending register decouples sample arrival from PWM period boundaries.
// PARAMETERS
//  PWM_BITS  8  PWM resolution; period = 2**PWM_BITS clocks; legal 4..12; ERR_BITS = 16-PWM_BITS
// PORTS
//  clk_in             in   1         system clock
//  reset_n_in         in   1         asynchronous reset, active-low
//  enable_in          in   1         1 = run; 0 = synchronous idle (see BEHAVIOUR)
//  sample_in          in   16        signed two's-complement mixed sample
//  sample_valid_in    in   1         1-cycle pulse: sample_in valid this cycle
//  pwm_out            out  1         registered PWM output
//  consume_out        out  1         1-cycle pulse: pending sample moved into the active slot
//  overrun_out        out  1         sticky: a pending sample was overwritten before consumption
// BEHAVIOUR
//  Reset (async, reset_n_in=0): cnt=0, duty=2**(PWM_BITS-1), err=0, cur=16'h8000, pend=16'h8000, pend_full=0,
//   pwm_out=0, consume_out=0, overrun_out=0. pwm_out goes low immediately, even mid-period.
//  Idle (enable_in=0, sampled at clk edge): every register forced to its reset value (incl. overrun_out clear);
//   sample_valid_in ignored. On the first enabled cycle cnt=0 and duty=midscale.
//  Input: off = sample_in ^ 16'h8000 (0x8000 = midscale, 0x7FFF -> 0xFFFF, 0x8000 -> 0x0000).
//  Pending: on sample_valid_in, pend<=off, pend_full<=1. If pend_full is already 1 and is not consumed in the same
//   cycle, overrun_out<=1 (sticky) and the newest sample wins.
//  Counter: cnt (PWM_BITS) increments every enabled clock, wraps max->0. "Wrap cycle" = cnt==max.
//  At the wrap cycle:
//   - src = pend_full ? pend : cur. If pend_full: cur<=pend, pend_full<=0, consume_out=1 next cycle.
//   - sum (17b) = src + {0,err}. If sum[16]: duty<=all ones, err<=0 (saturate).
//     Else duty<=sum[15:ERR_BITS], err<=sum[ERR_BITS-1:0].
//   - A sample_valid_in in the same cycle uses the OLD pend for src; the new value is written to pend and
//     pend_full stays/becomes 1; no overrun is flagged.
//  Output: pwm_out(k+1) = (cnt(k) < duty(k)). duty=0 -> always low; duty=max -> high (2**PWM_BITS)-1 of
//   2**PWM_BITS clocks. The new duty takes effect at cnt=0 of the next period (one-clock output latency).
//  Widths: all sums unsigned; no truncation except the saturation rule above. err persists across samples.
//  Timing: with the 1024-clock sample cadence and PWM_BITS=8, each sample covers 4 PWM periods; a sample is
//   consumed at most 2**PWM_BITS clocks after its valid pulse.
// TESTING
//  1. Reset, enable, no samples -> pwm_out high exactly 128 of every 256 clocks; consume_out never pulses.
//  2. sample 16'h8000 -> after the next wrap pwm_out constantly 0; consume_out pulses once.
//  3. sample 16'h7FFF -> duties 0xFF (err 0xFF), then 0xFF saturated (err 0), repeating; pwm_out low 1 clk/period.
//  4. sample 16'h0040 -> successive period duties 0x80,0x80,0x80,0x81, then repeat (mean 0x8040/256).
//  5. Two valid pulses (0x1000 then 0x2000) within one period -> overrun_out=1; duty derived from 0x2000^0x8000.
//     Valid coincident with wrap while pend_full -> old pend consumed, new pend kept, overrun_out stays 0.
//  6. reset_n_in low at cnt=0x40 with pwm_out=1 -> pwm_out=0 with no clock edge; enable_in=0 clears overrun_out.

Source files
------------

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: latches signed mixer samples, converts them to offset binary and
// drives a 1-bit PWM pin, carrying the truncated LSBs forward as first-order error feedback.
module pwm_audio_out #(
    parameter int PWM_BITS = 8
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        enable_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic        pwm_out,
    output logic        consume_out,
    output logic        overrun_out
);

    localparam int ERR_BITS = 16 - PWM_BITS;
    localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [15:0]         OFF_MID  = 16'h8000;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [ERR_BITS-1:0] err_q, err_d;
    logic [15:0]         cur_q, cur_d;
    logic [15:0]         pend_q, pend_d;
    logic                pendFull_q, pendFull_d;
    logic                pwm_q, pwm_d;
    logic                consume_q, consume_d;
    logic                overrun_q, overrun_d;

    logic [15:0] offSample;
    logic [15:0] src;
    logic [16:0] sum;
    logic        wrap;

    assign offSample = sample_in ^ OFF_MID;
    assign wrap      = (cnt_q == CNT_MAX);
    // A sample arriving on the wrap cycle still loses to the one already pending.
    assign src       = pendFull_q ? pend_q : cur_q;
    assign sum       = {1'b0, src} + {{(17-ERR_BITS){1'b0}}, err_q};

    always_comb begin
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        err_d      = err_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pendFull_d = pendFull_q;
        pwm_d      = pwm_q;
        consume_d  = 1'b0;
        overrun_d  = overrun_q;

        if (!enable_in) begin
            cnt_d      = '0;
            duty_d     = DUTY_MID;
            err_d      = '0;
            cur_d      = OFF_MID;
            pend_d     = OFF_MID;
            pendFull_d = 1'b0;
            pwm_d      = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            pwm_d = (cnt_q < duty_q);

            if (wrap) begin
                if (pendFull_q) begin
                    cur_d      = pend_q;
                    pendFull_d = 1'b0;
                    consume_d  = 1'b1;
                end
                if (sum[16]) begin
                    duty_d = '1;
                    err_d  = '0;
                end else begin
                    duty_d = sum[15:ERR_BITS];
                    err_d  = sum[ERR_BITS-1:0];
                end
            end

            if (sample_valid_in) begin
                pend_d     = offSample;
                pendFull_d = 1'b1;
                if (pendFull_q && !wrap) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt_q      <= '0;
            duty_q     <= DUTY_MID;
            err_q      <= '0;
            cur_q      <= OFF_MID;
            pend_q     <= OFF_MID;
            pendFull_q <= 1'b0;
            pwm_q      <= 1'b0;
            consume_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            err_q      <= err_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
            pwm_q      <= pwm_d;
            consume_q  <= consume_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign consume_out = consume_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Testbench for pwm_audio_out: directed scenarios with hand-derived duty patterns plus a
// randomized run compared cycle by cycle against a period-level arithmetic reference model.
module tb_pwm_audio_out;

    localparam int PWM_BITS = 8;
    localparam int ERR_BITS = 16 - PWM_BITS;
    localparam int PERIOD   = 1 << PWM_BITS;
    localparam int ERR_MOD  = 1 << ERR_BITS;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b1;
    logic        enable_in = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid_in = 1'b0;
    logic        pwm_out;
    logic        consume_out;
    logic        overrun_out;

    int total = 0;
    int bad   = 0;

    pwm_audio_out #(.PWM_BITS(PWM_BITS)) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .enable_in       (enable_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .pwm_out         (pwm_out),
        .consume_out     (consume_out),
        .overrun_out     (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: position within the PWM period, the current duty and the carried error.
    int mPos, mDuty, mErr, mCur, mPend;
    bit mPendFull, mPwm, mConsume, mOverrun;

    task automatic modelClear();
        mPos = 0; mDuty = PERIOD / 2; mErr = 0; mCur = 32'h8000; mPend = 32'h8000;
        mPendFull = 0; mPwm = 0; mConsume = 0; mOverrun = 0;
    endtask

    task automatic modelStep();
        bit atWrap;
        bit hadPending;
        int src;
        int sum;
        atWrap     = (mPos == PERIOD - 1);
        hadPending = mPendFull;
        mPwm       = (mPos < mDuty);
        mConsume   = atWrap && hadPending;
        if (atWrap) begin
            src = hadPending ? mPend : mCur;
            if (hadPending) begin
                mCur      = mPend;
                mPendFull = 0;
            end
            sum = src + mErr;
            if (sum >= 65536) begin
                mDuty = PERIOD - 1;
                mErr  = 0;
            end else begin
                mDuty = sum / ERR_MOD;
                mErr  = sum % ERR_MOD;
            end
        end
        if (sample_valid_in) begin
            if (hadPending && !atWrap) mOverrun = 1;
            mPend     = int'(sample_in ^ 16'h8000);
            mPendFull = 1;
        end
        mPos = (mPos + 1) % PERIOD;
    endtask

    always @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in || !enable_in) modelClear();
        else modelStep();
    end

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic applyReset();
        enable_in = 0;
        sample_valid_in = 0;
        reset_n_in = 0;
        tick();
        tick();
        reset_n_in = 1;
        tick();
    endtask

    task automatic sendSample(input logic [15:0] v);
        sample_in = v;
        sample_valid_in = 1;
        tick();
        sample_valid_in = 0;
    endtask

    task automatic waitConsume(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (consume_out === 1'b1) seen = 1;
        end
    endtask

    task automatic countWindow(input int n, output int highs, output int pulses);
        highs = 0;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
            if (consume_out === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        #2 reset_n_in = 0;
        #1;
        total++; if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_pwm: got %b expected 0", pwm_out); end
        total++; if (consume_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_consume: got %b expected 0", consume_out); end
        total++; if (overrun_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun_out); end
        applyReset();
    endtask

    task automatic test_idle_midscale();
        int highs;
        highs = 0;
        applyReset();
        enable_in = 1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (i <= 512 && pwm_out === 1'b1) highs++;
            total++;
            if (pwm_out !== mPwm) begin bad++; $display("[TB] FAIL midscale_pwm cycle %0d: got %b expected %b", i, pwm_out, mPwm); end
            total++;
            if (consume_out !== 1'b0) begin bad++; $display("[TB] FAIL midscale_consume cycle %0d: got %b expected 0", i, consume_out); end
        end
        total++;
        if (highs !== 256) begin bad++; $display("[TB] FAIL midscale_highs: got %0d expected 256", highs); end
    endtask

    task automatic test_sample_zero();
        bit seen;
        int highs, pulses;
        applyReset();
        enable_in = 1;
        tick();
        sendSample(16'h8000);
        waitConsume(300, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL zero_consume_seen: got %b expected 1", seen); end
        countWindow(512, highs, pulses);
        total++; if (highs !== 0) begin bad++; $display("[TB] FAIL zero_highs: got %0d expected 0", highs); end
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL zero_extra_consume: got %0d expected 0", pulses); end
    endtask

    task automatic test_full_scale();
        bit seen;
        int highs, pulses;
        applyReset();
        enable_in = 1;
        tick();
        sendSample(16'h7FFF);
        waitConsume(300, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL full_consume_seen: got %b expected 1", seen); end
        for (int p = 0; p < 4; p++) begin
            countWindow(PERIOD, highs, pulses);
            total++;
            if (highs !== 255) begin bad++; $display("[TB] FAIL full_period%0d_highs: got %0d expected 255", p, highs); end
        end
    endtask

    task automatic test_noise_shaping();
        bit seen;
        int highs, pulses;
        int expHighs[8];
        expHighs = '{128, 128, 128, 129, 128, 128, 128, 129};
        applyReset();
        enable_in = 1;
        tick();
        sendSample(16'h0040);
        waitConsume(300, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL shape_consume_seen: got %b expected 1", seen); end
        for (int p = 0; p < 8; p++) begin
            countWindow(PERIOD, highs, pulses);
            total++;
            if (highs !== expHighs[p]) begin bad++; $display("[TB] FAIL shape_period%0d_highs: got %0d expected %0d", p, highs, expHighs[p]); end
        end
    endtask

    task automatic test_overrun();
        bit seen;
        int highs, pulses;
        applyReset();
        enable_in = 1;
        for (int i = 0; i < 5; i++) tick();
        sendSample(16'h1000);
        total++; if (overrun_out !== 1'b0) begin bad++; $display("[TB] FAIL overrun_first: got %b expected 0", overrun_out); end
        for (int i = 0; i < 5; i++) tick();
        sendSample(16'h2000);
        total++; if (overrun_out !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun_out); end
        waitConsume(300, seen);
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL overrun_consume_seen: got %b expected 1", seen); end
        countWindow(PERIOD, highs, pulses);
        total++; if (highs !== 160) begin bad++; $display("[TB] FAIL overrun_newest_duty: got %0d expected 160", highs); end
        total++; if (overrun_out !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun_out); end
    endtask

    task automatic test_back_to_back();
        bit reached;
        int highs, pulses;
        applyReset();
        enable_in = 1;
        for (int i = 0; i < 3; i++) tick();
        sendSample(16'h1000);
        reached = 0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (mPos == PERIOD - 1) reached = 1;
            else tick();
        end
        total++; if (reached !== 1'b1) begin bad++; $display("[TB] FAIL b2b_wrap_reached: got %b expected 1", reached); end
        sendSample(16'h2000);
        total++; if (consume_out !== 1'b1) begin bad++; $display("[TB] FAIL b2b_consume: got %b expected 1", consume_out); end
        total++; if (overrun_out !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_overrun: got %b expected 0", overrun_out); end
        countWindow(PERIOD, highs, pulses);
        total++; if (highs !== 144) begin bad++; $display("[TB] FAIL b2b_old_duty: got %0d expected 144", highs); end
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL b2b_second_consume: got %0d expected 1", pulses); end
        countWindow(PERIOD, highs, pulses);
        total++; if (highs !== 160) begin bad++; $display("[TB] FAIL b2b_new_duty: got %0d expected 160", highs); end
        total++; if (overrun_out !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun_end: got %b expected 0", overrun_out); end
    endtask

    task automatic test_async_reset_and_idle();
        bit reached;
        applyReset();
        enable_in = 1;
        reached = 0;
        for (int i = 0; i < 300 && !reached; i++) begin
            tick();
            if (mPos == 8'h41) reached = 1;
        end
        total++; if (reached !== 1'b1) begin bad++; $display("[TB] FAIL async_pos_reached: got %b expected 1", reached); end
        total++; if (pwm_out !== 1'b1) begin bad++; $display("[TB] FAIL async_pwm_before: got %b expected 1", pwm_out); end
        #2 reset_n_in = 0;
        #1;
        total++; if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL async_pwm_after: got %b expected 0", pwm_out); end
        @(negedge clk_in);
        reset_n_in = 1;
        tick();
        tick();
        sendSample(16'h1234);
        tick();
        sendSample(16'h4321);
        total++; if (overrun_out !== 1'b1) begin bad++; $display("[TB] FAIL idle_overrun_set: got %b expected 1", overrun_out); end
        enable_in = 0;
        tick();
        total++; if (overrun_out !== 1'b0) begin bad++; $display("[TB] FAIL idle_overrun_clear: got %b expected 0", overrun_out); end
        total++; if (pwm_out !== 1'b0) begin bad++; $display("[TB] FAIL idle_pwm: got %b expected 0", pwm_out); end
    endtask

    task automatic test_random();
        int offLeft;
        offLeft = 0;
        applyReset();
        for (int i = 0; i < 6000; i++) begin
            if (offLeft > 0) begin
                enable_in = 0;
                offLeft--;
            end else begin
                enable_in = 1;
                if ($urandom_range(0, 999) == 0) offLeft = $urandom_range(1, 5);
            end
            sample_valid_in = ($urandom_range(0, 119) == 0);
            sample_in = 16'($urandom);
            tick();
            total++;
            if (pwm_out !== mPwm) begin bad++; $display("[TB] FAIL rand_pwm cycle %0d: got %b expected %b", i, pwm_out, mPwm); end
            total++;
            if (consume_out !== mConsume) begin bad++; $display("[TB] FAIL rand_consume cycle %0d: got %b expected %b", i, consume_out, mConsume); end
            total++;
            if (overrun_out !== mOverrun) begin bad++; $display("[TB] FAIL rand_overrun cycle %0d: got %b expected %b", i, overrun_out, mOverrun); end
        end
        sample_valid_in = 0;
    endtask

    initial begin
        test_reset();
        test_idle_midscale();
        test_sample_zero();
        test_full_scale();
        test_noise_shaping();
        test_overrun();
        test_back_to_back();
        test_async_reset_and_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
